module_lector_teclado: RTL
==========================

// Module: module_lector_teclado
// PURPOSE
//  Row-side reader for the 4x4 matrix keypad: consumes the 2-bit column index from the
//  free-running column scanner plus the raw keypad row lines, samples each column once
//  per visit, debounces and emits one encoded key per press. Output feeds the
//  input/arithmetic logic.
// PARAMETERS
//  SETTLE_CYCLES    16    clk cycles after a col_sel change before rows are sampled (incl. sync)
//  DEBOUNCE_SAMPLES 3     consecutive same-column samples required for press and for release
//  ROW_ACTIVE_LOW   1'b1  1: row_in pulled up, pressed key reads 0; 0: active-high rows
//  REPEAT_SAMPLES   50    same-column samples between auto-repeats (KEYPAD_REPEAT_EN only)
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous, active-high reset
//  col_sel    in   2  binary index of currently driven column, from column scanner
//  row_in     in   4  raw asynchronous keypad rows [3:0]
//  key_code   out  4  encoded key, held until next accepted press
//  key_valid  out  1  one-cycle pulse: key_code newly valid
//  key_held   out  1  high while debounced key is down
// BEHAVIOUR
//  - Interface: one clock (clk); reset rst is asynchronous, active-high. All flops reset.
//  - Reset values: key_code=4'h0, key_valid=0, key_held=0, FSM=IDLE, counters=0, sync=inactive.
//  - row_in -> 2-FF synchronizer, normalized to active-high (invert if ROW_ACTIVE_LOW).
//  - col_sel registered; any change reloads settle counter with SETTLE_CYCLES. Counter hitting 0
//    issues ONE sample strobe for that column visit. Change before 0 -> restart, no sample.
//  - Sample = {col, rows}; "single" iff exactly one row bit set; 0 or >=2 rows = no key.
//  - Code map (row r, col c): r0 "1 2 3 A", r1 "4 5 6 B", r2 "7 8 9 C", r3 "* 0 # D";
//    digits -> 4'h0-9, A-D -> 4'hA-D, '*' -> 4'hE, '#' -> 4'hF.
//  - FSM states IDLE, DEBOUNCE, PRESSED:
//    IDLE: single sample -> latch cand={r,c}, cnt=1, -> DEBOUNCE.
//    DEBOUNCE: only samples of cand column count; cand row single -> cnt+1; other/none/multi
//      -> IDLE. cnt==DEBOUNCE_SAMPLES -> PRESSED; key_code<=map(cand), key_valid=1 for the
//      cycle after the qualifying strobe. DEBOUNCE_SAMPLES==1: IDLE -> PRESSED directly.
//    PRESSED: key_held=1. Cand-column sample with cand row inactive -> rel+1, active -> rel=0;
//      rel==DEBOUNCE_SAMPLES -> IDLE, key_held=0 next cycle. Other columns ignored
//      (second key during hold never reported; no rollover).
//  - Counters saturate; no wrap. Strobe and col_sel change same cycle: strobe wins, reload after.
//  - Reset mid-press: IDLE, key_held=0; still-pressed key needs full debounce, reports again.
// CONFIGURATION
//  KEYPAD_REPEAT_EN defined: in PRESSED a repeat counter advances per cand-column sample;
//    at REPEAT_SAMPLES re-pulse key_valid (same key_code), counter clears; cleared on release.
//  Undefined: exactly one key_valid per press; no repeat counter logic.
// STRUCTURE
//  keypad_pkg: state enum (IDLE/DEBOUNCE/PRESSED), key code localparams (KEY_STAR=4'hE,
//    KEY_HASH=4'hF), function key_map(row_idx, col_idx) -> code, onehot-to-index function.
//  Sub-module keypad_row_sync: parameterized-width 2-FF synchronizer with async reset.
// TESTING (SETTLE_CYCLES=16, DEBOUNCE_SAMPLES=3, ROW_ACTIVE_LOW=1, col_sel cycling 0..3 every 100 clk)
//  1 Hold row_in=4'b1101 (row1) in col 2 -> exactly one key_valid, key_code=4'h6, after the 3rd
//    col-2 sample; key_held high until 3 col-2 samples after release.
//  2 Bounce: row1/col0 active for 2 col-0 samples, then off 1, then on -> no pulse until 3
//    consecutive; then key_code=4'h4.
//  3 Two rows in same column (row_in=4'b1100 at col 3) -> no key_valid, FSM stays IDLE.
//  4 row3/col0 then row3/col2 pressed -> codes 4'hE then 4'hF; key_code holds 4'hE between.
//  5 col_sel toggles every 10 clk (< SETTLE_CYCLES) with a key down -> no strobes, no key_valid.
//  6 rst pulsed mid-PRESSED (asynchronously, off clock edge) -> outputs 0 at once; key still
//    down -> new key_valid after 3 samples. With KEYPAD_REPEAT_EN, REPEAT_SAMPLES=5: held
//    key re-pulses every 5 cand-column samples.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and key encoding for the 4x4 keypad row reader.
// Used by module_lector_teclado and keypad_row_sync.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED
    } kp_state_e;

    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    function automatic logic [3:0] key_map(
        input logic [1:0] row_idx,
        input logic [1:0] col_idx
    );
        logic [3:0] code;
        code = 4'h0;
        if (col_idx == 2'd3) begin
            code = 4'hA + {2'b00, row_idx};
        end else if (row_idx != 2'd3) begin
            code = {2'b00, row_idx} * 4'd3 + {2'b00, col_idx} + 4'd1;
        end else begin
            unique case (col_idx)
                2'd0:    code = KEY_STAR;
                2'd1:    code = 4'h0;
                default: code = KEY_HASH;
            endcase
        end
        return code;
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) idx = i[1:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the raw keypad row lines.
// Reset value is the idle level of the lines so no phantom press appears.
module keypad_row_sync #(
    parameter int              WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/module_lector_teclado.sv
// Keypad row reader: per-column sampling, debounce, one code per press.
// Optional auto-repeat while held: define KEYPAD_REPEAT_EN.
module module_lector_teclado
    import keypad_pkg::*;
#(
    parameter int   SETTLE_CYCLES    = 16,
    parameter int   DEBOUNCE_SAMPLES = 3,
    parameter logic ROW_ACTIVE_LOW   = 1'b1,
    parameter int   REPEAT_SAMPLES   = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] col_sel,
    input  logic [3:0] row_in,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int CW = $clog2(DEBOUNCE_SAMPLES + 1);
    localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] DEB_N     = CW'(DEBOUNCE_SAMPLES);

    logic [3:0]    row_sync;
    logic [3:0]    rows;
    logic [1:0]    col_q;
    logic [SW-1:0] settle_q, settle_d;
    logic          armed_q, armed_d;
    logic          strobe;

    kp_state_e     state_q, state_d;
    logic [1:0]    cand_row_q, cand_row_d;
    logic [1:0]    cand_col_q, cand_col_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CW-1:0] rel_q, rel_d, rel_inc;
    logic [3:0]    code_q, code_d;
    logic          valid_q, valid_d;
    logic          single, cand_hit, cand_on;
    logic [1:0]    row_idx;

    keypad_row_sync #(
        .WIDTH   (4),
        .RST_VAL ({4{ROW_ACTIVE_LOW}})
    ) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d_i (row_in),
        .q_o (row_sync)
    );

    assign rows = ROW_ACTIVE_LOW ? ~row_sync : row_sync;

    // One strobe per column visit; a change in the strobe cycle still reloads.
    always_comb begin
        settle_d = settle_q;
        armed_d  = armed_q;
        strobe   = armed_q && (settle_q == '0);
        if (col_sel != col_q) begin
            settle_d = SETTLE_LD;
            armed_d  = 1'b1;
        end else if (strobe) begin
            armed_d = 1'b0;
        end else if (settle_q != '0) begin
            settle_d = settle_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q    <= 2'd0;
            settle_q <= '0;
            armed_q  <= 1'b0;
        end else begin
            col_q    <= col_sel;
            settle_q <= settle_d;
            armed_q  <= armed_d;
        end
    end

    assign single   = $onehot(rows);
    assign row_idx  = onehot_idx(rows);
    assign cand_hit = (col_q == cand_col_q);
    assign cand_on  = single && (row_idx == cand_row_q);
    assign cnt_inc  = (cnt_q == DEB_N) ? cnt_q : cnt_q + 1'b1;
    assign rel_inc  = (rel_q == DEB_N) ? rel_q : rel_q + 1'b1;

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_SAMPLES + 1);
    localparam logic [RW-1:0] RPT_N = RW'(REPEAT_SAMPLES);
    logic [RW-1:0] rpt_q, rpt_d, rpt_inc;
    assign rpt_inc = (rpt_q == RPT_N) ? rpt_q : rpt_q + 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        cand_row_d = cand_row_q;
        cand_col_d = cand_col_q;
        cnt_d      = cnt_q;
        rel_d      = rel_q;
        code_d     = code_q;
        valid_d    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rpt_d      = rpt_q;
`endif
        if (strobe) begin
            unique case (state_q)
                IDLE: begin
                    if (single) begin
                        cand_row_d = row_idx;
                        cand_col_d = col_q;
                        cnt_d      = CW'(1);
                        rel_d      = '0;
                        if (DEBOUNCE_SAMPLES <= 1) begin
                            state_d = PRESSED;
                            code_d  = key_map(row_idx, col_q);
                            valid_d = 1'b1;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (cand_hit) begin
                        if (!cand_on) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else if (cnt_inc >= DEB_N) begin
                            state_d = PRESSED;
                            cnt_d   = cnt_inc;
                            rel_d   = '0;
                            code_d  = key_map(cand_row_q, cand_col_q);
                            valid_d = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                PRESSED: begin
                    if (cand_hit) begin
                        if (rows[cand_row_q]) begin
                            rel_d = '0;
                        end else begin
                            rel_d = rel_inc;
                        end
`ifdef KEYPAD_REPEAT_EN
                        if (rpt_inc >= RPT_N) begin
                            rpt_d   = '0;
                            valid_d = 1'b1;
                        end else begin
                            rpt_d = rpt_inc;
                        end
`endif
                        if (!rows[cand_row_q] && rel_inc >= DEB_N) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                            rel_d   = '0;
                            valid_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
                            rpt_d   = '0;
`endif
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cand_row_q <= 2'd0;
            cand_col_q <= 2'd0;
            cnt_q      <= '0;
            rel_q      <= '0;
            code_q     <= 4'h0;
            valid_q    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rpt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cand_row_q <= cand_row_d;
            cand_col_q <= cand_col_d;
            cnt_q      <= cnt_d;
            rel_q      <= rel_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
`ifdef KEYPAD_REPEAT_EN
            rpt_q      <= rpt_d;
`endif
        end
    end

    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = (state_q == PRESSED);

endmodule
